// File: rtl/wdt_pkg.sv
// -----------------------------------------------------------------------------
// wdt_pkg
//   Shared types and constants for the windowed watchdog supervisor.
//   - wdt_state_t : supervisor FSM states
//   - KEY1_DEF / KEY2_DEF : default refresh key byte sequence
// -----------------------------------------------------------------------------
package wdt_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_KEY1 = 3'd2,
    ST_WARN = 3'd3,
    ST_BITE = 3'd4
  } wdt_state_t;

  localparam logic [7:0] KEY1_DEF = 8'hA5;
  localparam logic [7:0] KEY2_DEF = 8'h5A;

endpackage : wdt_pkg

// File: rtl/wdt_bite_pulse.sv
// -----------------------------------------------------------------------------
// wdt_bite_pulse
//   Generates a fixed-width reset request pulse of RST_PULSE cycles.
//   Ports:
//     clk, rst_n : clock, async active-low reset (truncates a running pulse)
//     start_i    : 1-cycle strobe; pulse_o rises on the following cycle
//     pulse_o    : reset request, high for exactly RST_PULSE cycles
//     busy_o     : pulse in progress (same as pulse_o)
//     done_o     : high during the last cycle of the pulse
// -----------------------------------------------------------------------------
module wdt_bite_pulse #(
  parameter int RST_PULSE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic pulse_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  logic          busy_q;
  logic [CW-1:0] left_q;   // cycles remaining after the current one

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same clock edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      left_q <= '0;
    end else if (start_i && !busy_q) begin
      busy_q <= 1'b1;
      left_q <= CW'(RST_PULSE - 1);
    end else if (busy_q) begin
      if (left_q == '0) busy_q <= 1'b0;
      else              left_q <= left_q - CW'(1);
    end
  end

  assign pulse_o = busy_q;
  assign busy_o  = busy_q;
  assign done_o  = busy_q && (left_q == '0);

endmodule : wdt_bite_pulse

// File: rtl/wdt_supervisor.sv
// -----------------------------------------------------------------------------
// wdt_supervisor
//   Windowed watchdog controller: counts while armed, accepts a two-byte keyed
//   refresh over valid/ready, raises an early-warning IRQ and finally requests
//   a fixed-width system reset (bite).
//   Build option: define WDT_WINDOW_EN to enable the early-refresh window
//   check; otherwise the window is 0 and cfg_window is ignored.
//   Ports:
//     clk, rst_n         : clock, async active-low reset
//     enable             : watchdog armed (level)
//     cfg_we             : config write strobe (honoured in IDLE only)
//     cfg_timeout        : timeout in cycles (0 is stored as 1)
//     cfg_window         : earliest legal refresh count
//     kick_valid/ready   : key byte handshake, kick_data carries the byte
//     warn_irq           : early warning level
//     sys_rst_req        : reset request pulse, RST_PULSE cycles
//     bad_kick           : 1-cycle pulse on wrong key or early refresh
//     bite_sts           : sticky bite flag, cleared by cfg_we in IDLE
//     cnt_out            : current count
// -----------------------------------------------------------------------------
module wdt_supervisor
  import wdt_pkg::*;
#(
  parameter int         CNT_W       = 16,
  parameter int         DEF_TIMEOUT = 50,
  parameter int         WARN_MARGIN = 8,
  parameter int         RST_PULSE   = 4,
  parameter logic [7:0] KEY1        = KEY1_DEF,
  parameter logic [7:0] KEY2        = KEY2_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic             kick_valid,
  input  logic [7:0]       kick_data,
  output logic             kick_ready,
  output logic             warn_irq,
  output logic             sys_rst_req,
  output logic             bad_kick,
  output logic             bite_sts,
  output logic [CNT_W-1:0] cnt_out
);

  wdt_state_t       state_q, state_d, base_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] window_r, warn_thresh;
  logic             warn_q, warn_d;
  logic             bite_sts_q, bite_sts_d;
  logic             bad_kick_q, bad_kick_d;
  logic             bite_start, pulse_busy, pulse_done;
  logic             kick_acc, pending, warn_hit, refresh_ok, refresh_early;

  wire cfg_wr = cfg_we && (state_q == ST_IDLE);

`ifdef WDT_WINDOW_EN
  logic [CNT_W-1:0] window_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      window_q <= '0;
    else if (cfg_wr) window_q <= cfg_window;
  end
  assign window_r = window_q;
`else
  logic unused_cfg_window;
  assign unused_cfg_window = ^cfg_window;
  assign window_r = '0;
`endif

  // Short timeouts leave no room for a margin: warn at the very first count.
  assign warn_thresh = (timeout_q > CNT_W'(WARN_MARGIN)) ?
                       timeout_q - CNT_W'(WARN_MARGIN) : '0;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
    warn_d        = warn_q;
    bite_sts_d    = bite_sts_q;
    bad_kick_d    = 1'b0;
    bite_start    = 1'b0;
    kick_ready    = (state_q == ST_RUN) || (state_q == ST_KEY1) || (state_q == ST_WARN);
    kick_acc      = kick_valid && kick_ready;
    pending       = (state_q == ST_KEY1);
    warn_hit      = 1'b0;
    refresh_ok    = 1'b0;
    refresh_early = 1'b0;
    base_state    = ST_RUN;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        warn_d = 1'b0;
        if (cfg_wr) begin
          timeout_d  = (cfg_timeout == '0) ? CNT_W'(1) : cfg_timeout;
          bite_sts_d = 1'b0;
        end
        if (enable) state_d = ST_RUN;
      end

      ST_RUN, ST_KEY1, ST_WARN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          warn_d  = 1'b0;
        end else begin
          cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          warn_hit   = (cnt_q == warn_thresh);
          if (warn_hit) warn_d = 1'b1;
          // KEY1-pending is orthogonal to warning; this is where we fall back to.
          base_state = (warn_q || warn_hit) ? ST_WARN : ST_RUN;
          state_d    = pending ? ST_KEY1 : base_state;
          if (kick_acc) begin
            if (pending && kick_data == KEY2) begin
              if (cnt_q >= window_r) refresh_ok    = 1'b1;
              else                   refresh_early = 1'b1;
            end else if (!pending && kick_data == KEY1) begin
              state_d = ST_KEY1;
            end else begin
              bad_kick_d = 1'b1;
              state_d    = base_state;
            end
          end
          // A legal refresh beats a timeout landing on the same cycle.
          if (refresh_ok) begin
            cnt_d   = '0;
            warn_d  = 1'b0;
            state_d = ST_RUN;
          end else if (refresh_early || cnt_q == timeout_q) begin
            bad_kick_d = refresh_early;
            bite_start = 1'b1;
            bite_sts_d = 1'b1;
            cnt_d      = '0;
            warn_d     = 1'b0;
            state_d    = ST_BITE;
          end
        end
      end

      ST_BITE: begin
        cnt_d  = '0;
        warn_d = 1'b0;
        // The pulse always runs to completion, whatever enable does meanwhile.
        if (pulse_done || !pulse_busy) state_d = enable ? ST_RUN : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the configuration registers are reset too: the watchdog must come up
  // with a known DEF_TIMEOUT even if software never writes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      timeout_q  <= CNT_W'(DEF_TIMEOUT);
      warn_q     <= 1'b0;
      bite_sts_q <= 1'b0;
      bad_kick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      warn_q     <= warn_d;
      bite_sts_q <= bite_sts_d;
      bad_kick_q <= bad_kick_d;
    end
  end

  wdt_bite_pulse #(.RST_PULSE(RST_PULSE)) u_bite_pulse (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (bite_start),
    .pulse_o (sys_rst_req),
    .busy_o  (pulse_busy),
    .done_o  (pulse_done)
  );

  assign warn_irq = warn_q;
  assign bad_kick = bad_kick_q;
  assign bite_sts = bite_sts_q;
  assign cnt_out  = cnt_q;

endmodule : wdt_supervisor

// File: tb/tb_wdt_supervisor.sv
// -----------------------------------------------------------------------------
// tb_wdt_supervisor
//   Directed bench for wdt_supervisor. Inputs are driven and outputs sampled on
//   the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_wdt_supervisor;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             cfg_we;
  logic [CNT_W-1:0] cfg_timeout;
  logic [CNT_W-1:0] cfg_window;
  logic             kick_valid;
  logic [7:0]       kick_data;
  logic             kick_ready;
  logic             warn_irq;
  logic             sys_rst_req;
  logic             bad_kick;
  logic             bite_sts;
  logic [CNT_W-1:0] cnt_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wdt_supervisor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_timeout (cfg_timeout),
    .cfg_window  (cfg_window),
    .kick_valid  (kick_valid),
    .kick_data   (kick_data),
    .kick_ready  (kick_ready),
    .warn_irq    (warn_irq),
    .sys_rst_req (sys_rst_req),
    .bad_kick    (bad_kick),
    .bite_sts    (bite_sts),
    .cnt_out     (cnt_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Writes config and arms in the same IDLE cycle; returns at RUN entry, cnt=0.
  task automatic start_run(input logic [CNT_W-1:0] tmo, input logic [CNT_W-1:0] win);
    cfg_we      = 1'b1;
    cfg_timeout = tmo;
    cfg_window  = win;
    enable      = 1'b1;
    tick(1);
    cfg_we      = 1'b0;
  endtask

  task automatic kick(input logic [7:0] b);
    kick_valid = 1'b1;
    kick_data  = b;
    tick(1);
    kick_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_timeout = '0; cfg_window = '0;
    kick_valid = 1'b0; kick_data = '0;
    repeat (2) @(negedge clk);

    check("rst_cnt",   32'(cnt_out), 0);
    check("rst_ready", 32'(kick_ready), 0);
    check("rst_warn",  32'(warn_irq), 0);
    check("rst_sysrst",32'(sys_rst_req), 0);
    check("rst_bite",  32'(bite_sts), 0);
    check("rst_bad",   32'(bad_kick), 0);
    rst_n = 1'b1;
    tick(1);

    // 1. timeout 20, no kicks: warn after cnt 12, bite cycles 21-24.
    start_run(16'd20, 16'd0);
    check("t1_cnt0",  32'(cnt_out), 0);
    check("t1_ready", 32'(kick_ready), 1);
    tick(12);
    check("t1_cnt12",  32'(cnt_out), 12);
    check("t1_warn12", 32'(warn_irq), 0);
    tick(1);
    check("t1_warn13", 32'(warn_irq), 1);
    tick(7);
    check("t1_cnt20",   32'(cnt_out), 20);
    check("t1_sys20",   32'(sys_rst_req), 0);
    tick(1);
    check("t1_sys21",   32'(sys_rst_req), 1);
    check("t1_bite21",  32'(bite_sts), 1);
    check("t1_warn21",  32'(warn_irq), 0);
    check("t1_cnt21",   32'(cnt_out), 0);
    check("t1_ready21", 32'(kick_ready), 0);
    tick(3);
    check("t1_sys24",   32'(sys_rst_req), 1);
    tick(1);
    check("t1_sys25",   32'(sys_rst_req), 0);
    check("t1_ready25", 32'(kick_ready), 1);
    enable = 1'b0;
    tick(1);
    check("t1_idle", 32'(kick_ready), 0);

    // 2. window 5: legal refresh at cnt 10, then early refresh at cnt 3.
    start_run(16'd20, 16'd5);
    check("t2_bite_clr", 32'(bite_sts), 0);
    tick(9);
    kick(8'hA5);
    kick(8'h5A);
    check("t2_cnt_ref", 32'(cnt_out), 0);
    check("t2_warn",    32'(warn_irq), 0);
    check("t2_bad0",    32'(bad_kick), 0);
    tick(2);
    kick(8'hA5);
    kick(8'h5A);
`ifdef WDT_WINDOW_EN
    check("t2_early_bad",  32'(bad_kick), 1);
    check("t2_early_sys",  32'(sys_rst_req), 1);
    check("t2_early_bite", 32'(bite_sts), 1);
`else
    check("t2_nowin_bad",  32'(bad_kick), 0);
    check("t2_nowin_sys",  32'(sys_rst_req), 0);
    check("t2_nowin_cnt",  32'(cnt_out), 0);
`endif
    enable = 1'b0;
    tick(5);
    check("t2_idle_ready", 32'(kick_ready), 0);
    check("t2_idle_sys",   32'(sys_rst_req), 0);

    // 3. wrong second key: bad_kick, no refresh, bite still at 20.
    start_run(16'd20, 16'd0);
    tick(4);
    kick(8'hA5);
    kick(8'h33);
    check("t3_bad",   32'(bad_kick), 1);
    check("t3_cnt6",  32'(cnt_out), 6);
    tick(1);
    check("t3_bad_off", 32'(bad_kick), 0);
    tick(13);
    check("t3_cnt20", 32'(cnt_out), 20);
    tick(1);
    check("t3_sys",   32'(sys_rst_req), 1);
    enable = 1'b0;
    tick(4);
    check("t3_idle",  32'(kick_ready), 0);

    // 4. KEY2 lands on cnt == timeout: refresh wins.
    start_run(16'd20, 16'd0);
    tick(19);
    kick(8'hA5);
    check("t4_cnt20", 32'(cnt_out), 20);
    check("t4_warn",  32'(warn_irq), 1);
    kick(8'h5A);
    check("t4_cnt0",  32'(cnt_out), 0);
    check("t4_warn0", 32'(warn_irq), 0);
    check("t4_sys0",  32'(sys_rst_req), 0);
    tick(1);
    check("t4_cnt1",  32'(cnt_out), 1);
    check("t4_sys1",  32'(sys_rst_req), 0);
    enable = 1'b0;
    tick(1);

    // 5. cfg_we while running is ignored; disable mid-bite keeps full pulse.
    start_run(16'd20, 16'd0);
    tick(3);
    cfg_we = 1'b1; cfg_timeout = 16'd100;
    tick(1);
    cfg_we = 1'b0;
    tick(16);
    check("t5_cnt20", 32'(cnt_out), 20);
    tick(1);
    check("t5_sys1",  32'(sys_rst_req), 1);
    enable = 1'b0;
    tick(3);
    check("t5_sys4",  32'(sys_rst_req), 1);
    tick(1);
    check("t5_sys5",  32'(sys_rst_req), 0);
    check("t5_idle",  32'(kick_ready), 0);

    // 6. async reset during bite cycle 2, then default timeout of 50.
    enable = 1'b1;
    tick(21);
    tick(2);
    check("t6_sys2", 32'(sys_rst_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_sys",   32'(sys_rst_req), 0);
    check("t6_rst_bite",  32'(bite_sts), 0);
    check("t6_rst_cnt",   32'(cnt_out), 0);
    check("t6_rst_ready", 32'(kick_ready), 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    tick(1);
    tick(42);
    check("t6_cnt42",  32'(cnt_out), 42);
    check("t6_warn42", 32'(warn_irq), 0);
    tick(1);
    check("t6_warn43", 32'(warn_irq), 1);
    tick(7);
    check("t6_sys50",  32'(sys_rst_req), 0);
    tick(1);
    check("t6_sys51",  32'(sys_rst_req), 1);
    enable = 1'b0;
    tick(4);

    // 7. timeout 0 stored as 1; margin larger than timeout warns at cnt 0.
    start_run(16'd0, 16'd0);
    check("t7_warn0", 32'(warn_irq), 0);
    tick(1);
    check("t7_warn1", 32'(warn_irq), 1);
    check("t7_cnt1",  32'(cnt_out), 1);
    tick(1);
    check("t7_sys",   32'(sys_rst_req), 1);
    check("t7_warnb", 32'(warn_irq), 0);
    enable = 1'b0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_wdt_supervisor
